// File: rtl/num_fetch_sched.sv
// Fetches DIGITS*ROWS glyph rows from the shared numbers memory and streams them out; NUM_FETCH_BLANK_EN adds leading-zero blanking.
// Latency: 3 cycles per beat minimum (REQ, WAIT, OUT); blanked beats take 1 cycle (OUT only).
// Backpressure: mem_gnt_i holds the request, mem_rvalid_i holds WAIT, and pix_ready_i low holds OUT with the row data stable.
module num_fetch_sched #(
   parameter int NUM_W  = 3,
   parameter int DIGITS = 6,
   parameter int ROWS   = 8,
   parameter int ROW_W  = 8,
   localparam int RW    = $clog2(ROWS),
   localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                    clk_sync_i,
   input  logic                    rst_n_i,
   input  logic                    start_i,
   input  logic [DIGITS*NUM_W-1:0] num_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    mem_req_o,
   output logic [NUM_W+RW-1:0]     mem_addr_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [ROW_W-1:0]        mem_rdata_i,
   output logic                    pix_valid_o,
   input  logic                    pix_ready_i,
   output logic [ROW_W-1:0]        pix_data_o,
   output logic [DW-1:0]           pix_digit_o,
   output logic [RW-1:0]           pix_row_o
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_DONE} state_t;

   state_t                  state_q;
   logic [DIGITS*NUM_W-1:0] snap_q;
   logic [DW-1:0]           digit_q;
   logic [RW-1:0]           row_q;
   logic [NUM_W-1:0]        snap_dig [DIGITS];
   logic [DIGITS-1:0]       blank;
   logic [DW-1:0]           nxt_digit;
   logic [RW-1:0]           nxt_row;
   logic                    last_beat;

   always_comb begin
      for (int k = 0; k < DIGITS; k++) begin
         snap_dig[k] = snap_q[k*NUM_W +: NUM_W];
      end
   end

`ifdef NUM_FETCH_BLANK_EN
   logic zero_above;

   // A digit is blank when it and everything more significant is zero; digit 0 always shows.
   always_comb begin
      zero_above = 1'b1;
      blank      = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above && (snap_dig[k] == '0);
         blank[k]   = zero_above;
      end
   end
`else
   assign blank = '0;
`endif

   assign last_beat = (digit_q == DW'(DIGITS - 1)) && (row_q == RW'(ROWS - 1));
   assign nxt_row   = row_q + 1'b1;
   assign nxt_digit = (row_q == RW'(ROWS - 1)) ? digit_q + 1'b1 : digit_q;

   assign pix_digit_o = digit_q;
   assign pix_row_o   = row_q;

   always_ff @(posedge clk_sync_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         snap_q      <= '0;
         digit_q     <= '0;
         row_q       <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_addr_o  <= '0;
         pix_valid_o <= 1'b0;
         pix_data_o  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  // Digit 0 is never blank, so the first beat always fetches.
                  snap_q     <= num_i;
                  digit_q    <= '0;
                  row_q      <= '0;
                  busy_o     <= 1'b1;
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= {num_i[NUM_W-1:0], {RW{1'b0}}};
                  state_q    <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_rvalid_i) begin
                  pix_data_o  <= mem_rdata_i;
                  pix_valid_o <= 1'b1;
                  state_q     <= S_OUT;
               end
            end
            S_OUT: begin
               if (pix_ready_i) begin
                  if (last_beat) begin
                     pix_valid_o <= 1'b0;
                     done_o      <= 1'b1;
                     digit_q     <= '0;
                     row_q       <= '0;
                     state_q     <= S_DONE;
                  end else begin
                     row_q   <= nxt_row;
                     digit_q <= nxt_digit;
                     if (blank[nxt_digit]) begin
                        pix_data_o <= '0;
                     end else begin
                        pix_valid_o <= 1'b0;
                        mem_req_o   <= 1'b1;
                        mem_addr_o  <= {snap_dig[nxt_digit], nxt_row};
                        state_q     <= S_REQ;
                     end
                  end
               end
            end
            S_DONE: begin
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_num_fetch_sched.sv
// Directed frame table plus hand sequences (backpressure, grant delay, mid-frame reset) for num_fetch_sched.
module tb_num_fetch_sched;

   logic        clk_sync_i = 1'b0;
   logic        rst_n_i;
   logic        start_i;
   logic [17:0] num_i;
   logic        busy_o, done_o, mem_req_o;
   logic [5:0]  mem_addr_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [7:0]  mem_rdata_i;
   logic        pix_valid_o, pix_ready_i;
   logic [7:0]  pix_data_o;
   logic [2:0]  pix_digit_o, pix_row_o;

`ifdef NUM_FETCH_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   num_fetch_sched dut (
      .clk_sync_i  (clk_sync_i),
      .rst_n_i     (rst_n_i),
      .start_i     (start_i),
      .num_i       (num_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i),
      .pix_valid_o (pix_valid_o),
      .pix_ready_i (pix_ready_i),
      .pix_data_o  (pix_data_o),
      .pix_digit_o (pix_digit_o),
      .pix_row_o   (pix_row_o)
   );

   always #5 clk_sync_i = ~clk_sync_i;

   typedef struct {
      logic [17:0] num;
      int          gnt_dly;
      int          rv_dly;
      int          stall_beat;
      int          stall_len;
      logic [17:0] chg_num;
      int          exp_busy;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] slot(input logic [17:0] n, input int d);
      logic [2:0] v;
      v = (d >= 0 && d < 6) ? n[d*3 +: 3] : 3'd0;
      return v;
   endfunction

   function automatic bit blank_exp(input logic [17:0] n, input int d);
      if (!BLANK_EN || d == 0) return 1'b0;
      for (int k = d; k < 6; k++) if (slot(n, k) != 3'd0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [7:0] data_of(input logic [5:0] a);
      return 8'(int'(a) * 37 + 11);
   endfunction

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"}, busy_o, 0);
      chk({nm, "_done"}, done_o, 0);
      chk({nm, "_req"}, mem_req_o, 0);
      chk({nm, "_addr"}, mem_addr_o, 0);
      chk({nm, "_valid"}, pix_valid_o, 0);
      chk({nm, "_data"}, pix_data_o, 0);
      chk({nm, "_digit"}, pix_digit_o, 0);
      chk({nm, "_row"}, pix_row_o, 0);
   endtask

   // Acts as memory, pixel sink and checker; everything is sampled and driven on the falling edge.
   task automatic run_frame(input vec_t v, input int rst_beat, input bit pre_started, output bit rst_hit);
      int beat = 0, req_wait = 0, wait_cnt = 0, stall_cnt = 0, cyc = 0;
      int n_req = 0, exp_req = 0, busy_cnt = 0, d, r;
      bit pending = 0, done_seen = 0, mid_start = 0;
      logic [5:0] ea;
      logic [7:0] ed;
      rst_hit = 1'b0;
      if (!pre_started) begin
         @(negedge clk_sync_i);
         num_i   = v.num;
         start_i = 1'b1;
      end
      @(negedge clk_sync_i);
      start_i = 1'b0;
      num_i   = v.chg_num;
      chk("start_busy", busy_o, 1);
      chk("start_req", mem_req_o, 1);
      while (!done_seen && cyc < 3000) begin
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = '0;
         pix_ready_i  = 1'b0;
         start_i      = 1'b0;
         d  = beat / 8;
         r  = beat % 8;
         ea = {slot(v.num, d), 3'(r)};
         ed = blank_exp(v.num, d) ? 8'h00 : data_of(ea);
         if (done_o) begin
            done_seen = 1'b1;
            chk("done_beats", beat, 48);
            chk("done_busy", busy_o, 1);
            chk("done_valid", pix_valid_o, 0);
            chk("busy_cycles", busy_cnt, v.exp_busy);
            start_i = 1'b1;
         end else begin
            if (busy_o) busy_cnt++;
            if (mem_req_o) begin
               if (req_wait == 0) begin
                  n_req++;
                  chk("req_not_blank", blank_exp(v.num, d), 0);
               end
               chk("req_addr", mem_addr_o, ea);
               chk("req_no_valid", pix_valid_o, 0);
               if (req_wait == v.gnt_dly) begin
                  mem_gnt_i = 1'b1;
                  pending   = 1'b1;
                  req_wait  = 0;
                  wait_cnt  = 0;
               end else begin
                  req_wait++;
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i  = 8'hFF;
               end
            end else if (pending && !pix_valid_o) begin
               if (beat == rst_beat) begin
                  rst_n_i = 1'b0;
                  #1;
                  chk_all_zero("midrst");
                  rst_hit = 1'b1;
                  @(negedge clk_sync_i);
                  chk_all_zero("midrst_hold");
                  rst_n_i = 1'b1;
                  num_i   = v.num;
                  start_i = 1'b1;
                  return;
               end
               if (wait_cnt == v.rv_dly) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i  = data_of(ea);
                  pending      = 1'b0;
               end else begin
                  wait_cnt++;
               end
            end
            if (pix_valid_o) begin
               chk("pix_data", pix_data_o, ed);
               chk("pix_digit", pix_digit_o, d);
               chk("pix_row", pix_row_o, r);
               chk("pix_no_req", mem_req_o, 0);
               if (beat == v.stall_beat && stall_cnt < v.stall_len) begin
                  stall_cnt++;
               end else begin
                  pix_ready_i = 1'b1;
                  beat++;
               end
            end
            if (beat == 5 && !mid_start) begin
               start_i   = 1'b1;
               mid_start = 1'b1;
            end
         end
         @(negedge clk_sync_i);
         cyc++;
      end
      chk("frame_done_seen", done_seen, 1);
      for (int b = 0; b < 48; b++) if (!blank_exp(v.num, b / 8)) exp_req++;
      chk("req_count", n_req, exp_req);
      start_i     = 1'b0;
      pix_ready_i = 1'b0;
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      @(negedge clk_sync_i);
      chk("idle_busy2", busy_o, 0);
      chk("idle_req2", mem_req_o, 0);
   endtask

   localparam logic [17:0] NUM_A = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
   localparam logic [17:0] NUM_B = {3'd7, 3'd0, 3'd5, 3'd2, 3'd0, 3'd3};
   localparam logic [17:0] NUM_C = {3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0};
   localparam logic [17:0] NUM_7 = {6{3'd7}};

   initial begin
      vec_t vt[5];
      bit   hit;
      vt[0] = '{NUM_A, 0, 0, -1, 0, NUM_A, 144};
      vt[1] = '{NUM_A, 0, 0, 10, 4, NUM_A, 148};
      vt[2] = '{NUM_A, 3, 0, -1, 0, NUM_7, 288};
      vt[3] = '{NUM_B, 0, 2, -1, 0, NUM_B, 240};
      vt[4] = '{NUM_C, 0, 0, -1, 0, NUM_C, BLANK_EN ? 96 : 144};

      rst_n_i      = 1'b0;
      start_i      = 1'b0;
      num_i        = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      pix_ready_i  = 1'b0;
      repeat (3) @(negedge clk_sync_i);
      chk_all_zero("reset");
      rst_n_i = 1'b1;

      for (int i = 0; i < 5; i++) run_frame(vt[i], -1, 1'b0, hit);

      // Reset while waiting for read data on beat 20, then start right at release.
      run_frame(vt[0], 20, 1'b0, hit);
      chk("midrst_reached", hit, 1);
      run_frame(vt[0], -1, 1'b1, hit);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: actual running required finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/num_fetch_sched.md
NUM_FETCH_SCHED -- requirements
Module: num_fetch_sched

Interface
REQ-001 Parameter NUM_W, default 3, bit width of one digit value.
REQ-002 Parameter DIGITS, default 6, number of digit slots scheduled per frame.
REQ-003 Parameter ROWS, default 8, glyph rows per digit; power of two; RW = log2(ROWS).
REQ-004 Parameter ROW_W, default 8, glyph row data width.
REQ-005 Port clk_sync_i, input, 1 bit, single clock; all logic on its rising edge.
REQ-006 Port rst_n_i, input, 1 bit, asynchronous active-low reset.
REQ-007 Port start_i, input, 1 bit, single-cycle frame start strobe.
REQ-008 Port num_i, input, DIGITS*NUM_W bits, digit values already synchronous to clk_sync_i; slot k occupies bits [k*NUM_W +: NUM_W]; slot DIGITS-1 is the most significant.
REQ-009 Port busy_o, output, 1 bit, high while a frame is in progress.
REQ-010 Port done_o, output, 1 bit, one-cycle pulse when the frame completes.
REQ-011 Port mem_req_o, output, 1 bit, read request to the shared numbers memory.
REQ-012 Port mem_addr_o, output, NUM_W+RW bits, read address {digit value, row}.
REQ-013 Port mem_gnt_i, input, 1 bit, request accepted by the memory arbiter.
REQ-014 Port mem_rvalid_i, input, 1 bit, read data valid.
REQ-015 Port mem_rdata_i, input, ROW_W bits, read data.
REQ-016 Port pix_valid_o / pix_ready_i, output / input, 1 bit each, output row handshake.
REQ-017 Port pix_data_o, output, ROW_W bits; pix_digit_o, output, log2(DIGITS) bits; pix_row_o, output, RW bits.

Function
REQ-018 FSM states IDLE, REQ, WAIT, OUT, DONE; reset state IDLE.
REQ-019 IDLE: start_i=1 snapshots num_i into an internal register, clears digit and row counters to 0, enters REQ; busy_o rises on the next cycle.
REQ-020 start_i while busy_o=1 is ignored; num_i changes after the snapshot do not affect the current frame.
REQ-021 REQ: mem_req_o=1, mem_addr_o stable at {snap[digit], row}; held until mem_gnt_i=1, then enter WAIT the next cycle.
REQ-022 At most one outstanding read; mem_req_o=0 in all states except REQ.
REQ-023 WAIT: on mem_rvalid_i=1, register mem_rdata_i into pix_data_o and enter OUT; mem_rvalid_i outside WAIT is ignored.
REQ-024 OUT: pix_valid_o=1; pix_data_o, pix_digit_o, pix_row_o held stable until pix_ready_i=1.
REQ-025 On the OUT handshake, row increments; at row=ROWS-1 row wraps to 0 and digit increments; after digit=DIGITS-1 and row=ROWS-1, enter DONE, otherwise enter REQ.
REQ-026 Order: digit 0 rows 0..ROWS-1, then digit 1, ..., digit DIGITS-1; exactly DIGITS*ROWS beats per frame.
REQ-027 DONE lasts one cycle: done_o=1, then IDLE; busy_o is low from the IDLE cycle onward; start_i in the DONE cycle is ignored.
REQ-028 Minimum per-beat cost is 3 cycles (REQ, WAIT, OUT) with mem_gnt_i, mem_rvalid_i and pix_ready_i each high on first opportunity.

Reset
REQ-029 rst_n_i=0 forces IDLE immediately, even mid-frame; all outputs 0, counters and snapshot 0; no pending request survives.
REQ-030 Reset release is accepted asynchronously; the first start_i is honoured in the first cycle after release.

Configuration
REQ-031 Macro NUM_FETCH_BLANK_EN: when defined, leading-zero blanking is compiled in; when undefined, every digit is fetched from memory.
REQ-032 With NUM_FETCH_BLANK_EN defined, a digit is blank when its value is 0, every more-significant snapshot digit is 0, and it is not digit 0; a blank digit skips REQ/WAIT, emits its ROWS beats with pix_data_o=0, and issues no memory request.
REQ-033 Beat count, order and handshake are identical with and without the macro.

Verification
REQ-034 Reset, then start_i with num_i slots 5..0 = {1,2,3,4,5,6}, gnt/rvalid/ready tied high -> 48 beats, addresses {6,r},{5,r},...,{1,r}, done_o after 144 cycles of busy_o.
REQ-035 pix_ready_i low for 4 cycles on beat 10 -> outputs stable during the stall, no extra mem_req_o, beat order unchanged.
REQ-036 mem_gnt_i delayed 3 cycles per request and num_i changed mid-frame -> mem_addr_o held through the wait, addresses follow the snapshot.
REQ-037 rst_n_i asserted in WAIT during beat 20 -> all outputs 0 at once; subsequent start_i runs a full 48-beat frame.
REQ-038 NUM_FETCH_BLANK_EN defined, num_i slots 5..0 = {0,0,0,7,0,0} -> digits 5,4,3 emit zero rows with no mem_req_o; digits 2,1,0 fetched (values 7,0,0); 48 beats total.
